// File: rtl/wb_register_file_if.sv
// MEM/WB write-back and register-read bundle for wb_register_file.
// The master drives the pipeline fields and read indices; the slave returns read data and status.
interface wb_register_file_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   RegWrite;
  logic                   MemToReg;
  logic [31:0]            WriteRegister;
  logic [31:0]            ALUResult;
  logic [31:0]            DataMemory;
  logic [31:0]            Instruction;
  logic [4:0]             ReadRegister1;
  logic [4:0]             ReadRegister2;
  logic [31:0]            ReadData1;
  logic [31:0]            ReadData2;
  logic [31:0]            WriteData;
  logic [COUNT_WIDTH-1:0] RetiredCount;
  logic [4:0]             LastWriteReg;

  modport master (
    output RegWrite, MemToReg, WriteRegister, ALUResult, DataMemory, Instruction,
    output ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, WriteData, RetiredCount, LastWriteReg
  );

  modport slave (
    input  RegWrite, MemToReg, WriteRegister, ALUResult, DataMemory, Instruction,
    input  ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, WriteData, RetiredCount, LastWriteReg
  );
endinterface

// File: rtl/wb_register_file.sv
// 32x32 register file fed by the MEM/WB stage, with write-through bypass on both read ports,
// a retired-instruction counter and a record of the most recent committed destination.
module wb_register_file #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  wb_register_file_if.slave  bus
);

  logic [31:0]            regs_q [32];
  logic [31:0]            regs_d [32];
  logic [COUNT_WIDTH-1:0] retiredCount_q;
  logic [COUNT_WIDTH-1:0] retiredCount_d;
  logic [4:0]             lastWriteReg_q;
  logic [4:0]             lastWriteReg_d;

  logic [4:0]  writeIdx;
  logic [31:0] writeData;
  logic        commitWrite;
  logic        retire;
  logic [26:0] unusedWriteRegHigh;

  assign writeIdx           = bus.WriteRegister[4:0];
  assign unusedWriteRegHigh = bus.WriteRegister[31:5];
  assign writeData          = bus.MemToReg ? bus.DataMemory : bus.ALUResult;
  assign commitWrite        = bus.RegWrite && (writeIdx != 5'd0);
  // Retirement ignores the destination, so writes aimed at r0 still count.
  assign retire             = bus.RegWrite && (bus.Instruction != 32'd0);

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    retiredCount_d = retiredCount_q;
    lastWriteReg_d = lastWriteReg_q;
    if (commitWrite) begin
      regs_d[writeIdx] = writeData;
      lastWriteReg_d   = writeIdx;
    end
    if (retire) begin
      retiredCount_d = retiredCount_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      retiredCount_q <= '0;
      lastWriteReg_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      retiredCount_q <= retiredCount_d;
      lastWriteReg_q <= lastWriteReg_d;
    end
  end

  // Reads bypass the in-flight write-back value so the ID stage never sees stale data.
  always_comb begin
    bus.ReadData1 = 32'd0;
    if (bus.ReadRegister1 == 5'd0) begin
      bus.ReadData1 = 32'd0;
    end else if (commitWrite && (writeIdx == bus.ReadRegister1)) begin
      bus.ReadData1 = writeData;
    end else begin
      bus.ReadData1 = regs_q[bus.ReadRegister1];
    end
  end

  always_comb begin
    bus.ReadData2 = 32'd0;
    if (bus.ReadRegister2 == 5'd0) begin
      bus.ReadData2 = 32'd0;
    end else if (commitWrite && (writeIdx == bus.ReadRegister2)) begin
      bus.ReadData2 = writeData;
    end else begin
      bus.ReadData2 = regs_q[bus.ReadRegister2];
    end
  end

  assign bus.WriteData    = writeData;
  assign bus.RetiredCount = retiredCount_q;
  assign bus.LastWriteReg = lastWriteReg_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Scenario-driven bench for wb_register_file with a behavioural model and an expected-value queue.
module tb_wb_register_file;

  logic Clock;
  logic Reset;

  wb_register_file_if #(.COUNT_WIDTH(4)) bus ();

  wb_register_file #(.COUNT_WIDTH(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] expQ [$];
  logic [31:0] got;
  logic [31:0] exp;

  logic [31:0] mRegs [32];
  logic [3:0]  mCount;
  logic [4:0]  mLast;

  task automatic setIdle();
    bus.RegWrite      = 1'b0;
    bus.MemToReg      = 1'b1;
    bus.WriteRegister = 32'd0;
    bus.ALUResult     = 32'd0;
    bus.DataMemory    = 32'd0;
    bus.Instruction   = 32'd0;
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;
  endtask

  // Advance the model with the inputs as they stand, then let the DUT take the same edge.
  task automatic stepEdge();
    logic [31:0] wd;
    logic [4:0]  wi;
    wd = bus.MemToReg ? bus.DataMemory : bus.ALUResult;
    wi = bus.WriteRegister[4:0];
    if (Reset) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mCount = 4'd0;
      mLast  = 5'd0;
    end else begin
      if (bus.RegWrite && wi != 5'd0) begin
        mRegs[wi] = wd;
        mLast     = wi;
      end
      if (bus.RegWrite && bus.Instruction != 32'd0) mCount = mCount + 4'd1;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    setIdle();
    Reset = 1'b1;
    stepEdge();
    stepEdge();
    Reset = 1'b0;
    bus.ReadRegister1 = 5'd5;
    bus.ReadRegister2 = 5'd31;
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    #1;
    got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_count got=%h exp=%h", got, exp); end
    got = {27'd0, bus.LastWriteReg}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_last got=%h exp=%h", got, exp); end
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_r5 got=%h exp=%h", got, exp); end
    got = bus.ReadData2; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_r31 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_write_read();
    setIdle();
    bus.RegWrite      = 1'b1;
    bus.MemToReg      = 1'b0;
    bus.WriteRegister = 32'd5;
    bus.ALUResult     = 32'h0000_1234;
    bus.DataMemory    = 32'hDEAD_BEEF;
    bus.Instruction   = 32'h0000_0013;
    expQ.push_back(32'h0000_1234);
    #1;
    got = bus.WriteData; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wd_alu got=%h exp=%h", got, exp); end
    stepEdge();
    bus.RegWrite      = 1'b0;
    bus.ReadRegister1 = 5'd5;
    expQ.push_back(32'h0000_1234);
    expQ.push_back(32'd5);
    expQ.push_back(32'd1);
    #1;
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wr_read got=%h exp=%h", got, exp); end
    got = {27'd0, bus.LastWriteReg}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wr_last got=%h exp=%h", got, exp); end
    got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wr_count got=%h exp=%h", got, exp); end
  endtask

  task automatic test_bypass();
    setIdle();
    bus.RegWrite      = 1'b1;
    bus.MemToReg      = 1'b1;
    bus.WriteRegister = 32'hFFFF_FFE7;
    bus.ALUResult     = 32'h1111_1111;
    bus.DataMemory    = 32'hCAFE_F00D;
    bus.Instruction   = 32'h0000_0003;
    bus.ReadRegister1 = 5'd7;
    bus.ReadRegister2 = 5'd7;
    expQ.push_back(32'hCAFE_F00D);
    expQ.push_back(32'hCAFE_F00D);
    #1;
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bypass_p1 got=%h exp=%h", got, exp); end
    got = bus.ReadData2; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bypass_p2 got=%h exp=%h", got, exp); end
    stepEdge();
    bus.RegWrite      = 1'b0;
    bus.DataMemory    = 32'h0;
    bus.ReadRegister2 = 5'd5;
    expQ.push_back(32'hCAFE_F00D);
    expQ.push_back(32'h0000_1234);
    expQ.push_back(32'd7);
    #1;
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bypass_stored got=%h exp=%h", got, exp); end
    got = bus.ReadData2; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bypass_other got=%h exp=%h", got, exp); end
    got = {27'd0, bus.LastWriteReg}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bypass_last got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reg_zero();
    logic [4:0] lastBefore;
    logic [3:0] countBefore;
    lastBefore  = mLast;
    countBefore = mCount;
    setIdle();
    bus.RegWrite      = 1'b1;
    bus.MemToReg      = 1'b0;
    bus.WriteRegister = 32'd0;
    bus.ALUResult     = 32'hFFFF_FFFF;
    bus.Instruction   = 32'h0000_0020;
    bus.ReadRegister1 = 5'd0;
    expQ.push_back(32'd0);
    #1;
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL r0_during got=%h exp=%h", got, exp); end
    stepEdge();
    bus.RegWrite = 1'b0;
    expQ.push_back(32'd0);
    expQ.push_back({28'd0, countBefore + 4'd1});
    expQ.push_back({27'd0, lastBefore});
    #1;
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL r0_after got=%h exp=%h", got, exp); end
    got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL r0_count got=%h exp=%h", got, exp); end
    got = {27'd0, bus.LastWriteReg}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL r0_last got=%h exp=%h", got, exp); end
  endtask

  task automatic test_bubble();
    logic [3:0] countBefore;
    setIdle();
    bus.RegWrite      = 1'b1;
    bus.MemToReg      = 1'b0;
    bus.WriteRegister = 32'd9;
    bus.ALUResult     = 32'h0000_0055;
    bus.Instruction   = 32'h0000_0033;
    stepEdge();
    countBefore = mCount;
    setIdle();
    repeat (3) stepEdge();
    bus.ReadRegister1 = 5'd9;
    expQ.push_back(32'h0000_0055);
    expQ.push_back({28'd0, countBefore});
    expQ.push_back(32'd9);
    #1;
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bubble_r9 got=%h exp=%h", got, exp); end
    got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bubble_count got=%h exp=%h", got, exp); end
    got = {27'd0, bus.LastWriteReg}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bubble_last got=%h exp=%h", got, exp); end
  endtask

  task automatic test_write_no_retire();
    logic [3:0] countBefore;
    countBefore = mCount;
    setIdle();
    bus.RegWrite      = 1'b1;
    bus.MemToReg      = 1'b1;
    bus.WriteRegister = 32'd12;
    bus.DataMemory    = 32'h0BAD_F00D;
    bus.Instruction   = 32'd0;
    stepEdge();
    bus.RegWrite      = 1'b0;
    bus.ReadRegister2 = 5'd12;
    expQ.push_back(32'h0BAD_F00D);
    expQ.push_back({28'd0, countBefore});
    #1;
    got = bus.ReadData2; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL noret_r12 got=%h exp=%h", got, exp); end
    got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL noret_count got=%h exp=%h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  idx;
    logic [4:0]  prev;
    logic [31:0] data;
    prev = 5'd9;
    setIdle();
    for (int k = 0; k < 8; k++) begin
      idx  = 5'(16 + k);
      data = $urandom();
      bus.RegWrite      = 1'b1;
      bus.MemToReg      = k[0];
      bus.WriteRegister = ($urandom() & 32'hFFFF_FFE0) | {27'd0, idx};
      bus.ALUResult     = k[0] ? ~data : data;
      bus.DataMemory    = k[0] ? data : ~data;
      bus.Instruction   = 32'(k + 1);
      bus.ReadRegister1 = prev;
      bus.ReadRegister2 = idx;
      expQ.push_back(mRegs[prev]);
      expQ.push_back(data);
      #1;
      got = bus.ReadData1; exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_prev k=%0d got=%h exp=%h", k, got, exp); end
      got = bus.ReadData2; exp = expQ.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_bypass k=%0d got=%h exp=%h", k, got, exp); end
      stepEdge();
      prev = idx;
    end
    setIdle();
    expQ.push_back({28'd0, mCount});
    expQ.push_back({27'd0, mLast});
    #1;
    got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL b2b_count got=%h exp=%h", got, exp); end
    got = {27'd0, bus.LastWriteReg}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL b2b_last got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_collision();
    setIdle();
    bus.RegWrite      = 1'b1;
    bus.MemToReg      = 1'b0;
    bus.WriteRegister = 32'd3;
    bus.ALUResult     = 32'h0000_00AA;
    bus.Instruction   = 32'h0000_0001;
    bus.ReadRegister1 = 5'd3;
    bus.ReadRegister2 = 5'd20;
    Reset = 1'b1;
    expQ.push_back(32'h0000_00AA);
    #1;
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rstc_bypass got=%h exp=%h", got, exp); end
    stepEdge();
    Reset        = 1'b0;
    bus.RegWrite = 1'b0;
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    #1;
    got = bus.ReadData1; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rstc_r3 got=%h exp=%h", got, exp); end
    got = bus.ReadData2; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rstc_r20 got=%h exp=%h", got, exp); end
    got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rstc_count got=%h exp=%h", got, exp); end
    got = {27'd0, bus.LastWriteReg}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rstc_last got=%h exp=%h", got, exp); end
  endtask

  task automatic test_wrap();
    setIdle();
    bus.RegWrite      = 1'b1;
    bus.MemToReg      = 1'b0;
    bus.WriteRegister = 32'd0;
    bus.Instruction   = 32'h0000_0042;
    for (int n = 1; n <= 16; n++) begin
      stepEdge();
      if (n == 15) begin
        expQ.push_back(32'd15);
        got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_15 got=%h exp=%h", got, exp); end
      end
    end
    setIdle();
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    #1;
    got = {28'd0, bus.RetiredCount}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wrap_0 got=%h exp=%h", got, exp); end
    got = {27'd0, bus.LastWriteReg}; exp = expQ.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wrap_last got=%h exp=%h", got, exp); end
  endtask

  initial begin
    Reset  = 1'b0;
    mCount = 4'd0;
    mLast  = 5'd0;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    setIdle();
    test_reset();
    test_write_read();
    test_bypass();
    test_reg_zero();
    test_bubble();
    test_write_no_retire();
    test_back_to_back();
    test_reset_collision();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
